// File: rtl/button_cycle_bank_pkg.sv
// Shared definitions for the push-button colour/selection counter bank:
// channel FSM encoding, a width helper and the downstream colour indices.
package button_cycle_bank_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LOCK     = 2'd1,
        ST_WAIT_REL = 2'd2
    } ch_state_e;

    // Bits needed to hold values 0..value-1, never less than one.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

    localparam logic [2:0] COLOUR_WHITE  = 3'd0;
    localparam logic [2:0] COLOUR_RED    = 3'd1;
    localparam logic [2:0] COLOUR_GREEN  = 3'd2;
    localparam logic [2:0] COLOUR_BLUE   = 3'd3;
    localparam logic [2:0] COLOUR_ORANGE = 3'd4;
    localparam logic [2:0] COLOUR_BLACK  = 3'd5;

endpackage

// File: rtl/button_cycle_bank_lock_channel.sv
// One button channel: synchroniser, press/lockout/release FSM and the
// modulo counter it steps.
module btn_lock_channel
    import button_cycle_bank_pkg::*;
#(
    parameter int CNT_W         = 3,
    parameter int MODULO        = 6,
    parameter int LOCKOUT_TICKS = 200,
    parameter int SYNC_STAGES   = 2
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             tick,
    input  logic             EN,
    input  logic             DIR,
    input  logic             CLR,
    input  logic             btn,
    output logic [CNT_W-1:0] count,
    output logic             press
);

    localparam int               LOCK_W    = clog2(LOCKOUT_TICKS + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(MODULO - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCKOUT_TICKS);
    localparam logic [LOCK_W-1:0] LOCK_ONE  = LOCK_W'(1);

    logic [SYNC_STAGES-1:0] sync_p;
    logic                   btn_s;
    ch_state_e              state_q, state_d;
    logic [LOCK_W-1:0]      lock_q, lock_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   press_q, press_d;

    function automatic logic [CNT_W-1:0] step_count(input logic [CNT_W-1:0] c,
                                                    input logic down);
        if (down) begin
            return (c == '0) ? CNT_MAX : c - CNT_ONE;
        end
        return (c == CNT_MAX) ? '0 : c + CNT_ONE;
    endfunction

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync_p <= '0;
        end else begin
            sync_p <= {sync_p[SYNC_STAGES-2:0], btn};
        end
    end

    assign btn_s = sync_p[SYNC_STAGES-1];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            lock_q  <= '0;
            count_q <= '0;
            press_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
            count_q <= count_d;
            press_q <= press_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        count_d = count_q;
        press_d = 1'b0;
        if (!EN) begin
            // A button already held when enabling must be released first.
            state_d = btn_s ? ST_WAIT_REL : ST_IDLE;
            lock_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (btn_s) begin
                        count_d = step_count(count_q, DIR);
                        press_d = 1'b1;
                        lock_d  = LOCK_LOAD;
                        state_d = ST_LOCK;
                    end
                end
                ST_LOCK: begin
                    if (tick) begin
                        lock_d = (lock_q == '0) ? '0 : lock_q - LOCK_ONE;
                        if (lock_q <= LOCK_ONE) begin
                            state_d = btn_s ? ST_WAIT_REL : ST_IDLE;
                        end
                    end
                end
                ST_WAIT_REL: begin
                    if (!btn_s) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        // Clear wins over a same-cycle press, which is still consumed above.
        if (CLR) begin
            count_d = '0;
        end
    end

    assign count = count_q;
    assign press = press_q;

endmodule

// File: rtl/button_cycle_bank.sv
// Multi-channel push-button front end: shared lockout tick prescaler,
// one lockout channel per button and an all-channels-equal detector.
module button_cycle_bank
    import button_cycle_bank_pkg::*;
#(
    parameter int NUM_CH        = 3,
    parameter int CNT_W         = 3,
    parameter int MODULO        = 6,
    parameter int CLK_HZ        = 100_000_000,
    parameter int TICK_HZ       = 1000,
    parameter int LOCKOUT_TICKS = 200,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    EN,
    input  logic                    DIR,
    input  logic                    CLR,
    input  logic [NUM_CH-1:0]       btn,
    output logic [NUM_CH*CNT_W-1:0] count,
    output logic [NUM_CH-1:0]       press,
    output logic                    all_equal,
    output logic [CNT_W-1:0]        all_value
);

    localparam int               DIV      = CLK_HZ / TICK_HZ;
    localparam int               PRE_W    = clog2(DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);
    localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);

    logic [PRE_W-1:0] presc_q;
    logic             tick;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            presc_q <= '0;
        end else if (presc_q == PRE_LAST) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + PRE_ONE;
        end
    end

    assign tick = (presc_q == PRE_LAST);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        btn_lock_channel #(
            .CNT_W         (CNT_W),
            .MODULO        (MODULO),
            .LOCKOUT_TICKS (LOCKOUT_TICKS),
            .SYNC_STAGES   (SYNC_STAGES)
        ) u_ch (
            .CLK   (CLK),
            .RST_N (RST_N),
            .tick  (tick),
            .EN    (EN),
            .DIR   (DIR),
            .CLR   (CLR),
            .btn   (btn[i]),
            .count (count[i*CNT_W +: CNT_W]),
            .press (press[i])
        );
    end

    always_comb begin
        all_equal = 1'b1;
        for (int i = 1; i < NUM_CH; i++) begin
            if (count[i*CNT_W +: CNT_W] != count[CNT_W-1:0]) begin
                all_equal = 1'b0;
            end
        end
    end

    assign all_value = count[CNT_W-1:0];

endmodule

// File: tb/tb_button_cycle_bank.sv
// Bench for button_cycle_bank: directed scenarios plus random button traffic,
// every cycle compared with a tick/lockout reference model.
module tb_button_cycle_bank;

    localparam int NUM_CH        = 3;
    localparam int CNT_W         = 3;
    localparam int MODULO        = 6;
    localparam int CLK_HZ        = 1000;
    localparam int TICK_HZ       = 100;
    localparam int LOCKOUT_TICKS = 3;
    localparam int SYNC_STAGES   = 2;
    localparam int DIV           = CLK_HZ / TICK_HZ;

    logic                    CLK = 1'b0;
    logic                    RST_N;
    logic                    EN;
    logic                    DIR;
    logic                    CLR;
    logic [NUM_CH-1:0]       btn;
    logic [NUM_CH*CNT_W-1:0] count;
    logic [NUM_CH-1:0]       press;
    logic                    all_equal;
    logic [CNT_W-1:0]        all_value;

    always #5 CLK = ~CLK;

    button_cycle_bank #(
        .NUM_CH        (NUM_CH),
        .CNT_W         (CNT_W),
        .MODULO        (MODULO),
        .CLK_HZ        (CLK_HZ),
        .TICK_HZ       (TICK_HZ),
        .LOCKOUT_TICKS (LOCKOUT_TICKS),
        .SYNC_STAGES   (SYNC_STAGES)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .EN        (EN),
        .DIR       (DIR),
        .CLR       (CLR),
        .btn       (btn),
        .count     (count),
        .press     (press),
        .all_equal (all_equal),
        .all_value (all_value)
    );

    int    n_tests = 0;
    int    n_fail  = 0;
    string phase   = "reset";

    // Reference model: remaining lockout ticks and a must-release flag per channel.
    int                m_cnt   [NUM_CH];
    int                m_ticks [NUM_CH];
    bit                m_hold  [NUM_CH];
    bit [NUM_CH-1:0]   m_press;
    int                m_cyc;
    bit [NUM_CH-1:0]   m_sync [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] ch_count(input int ch);
        return 32'(count[ch*CNT_W +: CNT_W]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_cnt[i]   = 0;
            m_ticks[i] = 0;
            m_hold[i]  = 1'b0;
        end
        m_press = '0;
        m_cyc   = 0;
        m_sync.delete();
        for (int i = 0; i < SYNC_STAGES; i++) m_sync.push_back('0);
    endtask

    task automatic model_edge();
        bit              tk;
        bit [NUM_CH-1:0] bs;
        tk      = ((m_cyc % DIV) == DIV - 1);
        bs      = m_sync[0];
        m_press = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!EN) begin
                m_ticks[i] = 0;
                m_hold[i]  = bs[i];
            end else if (m_ticks[i] > 0) begin
                if (tk) begin
                    m_ticks[i]--;
                    if (m_ticks[i] == 0) m_hold[i] = bs[i];
                end
            end else if (m_hold[i]) begin
                m_hold[i] = bs[i];
            end else if (bs[i]) begin
                m_cnt[i]   = DIR ? (m_cnt[i] + MODULO - 1) % MODULO : (m_cnt[i] + 1) % MODULO;
                m_press[i] = 1'b1;
                m_ticks[i] = LOCKOUT_TICKS;
            end
            if (CLR) m_cnt[i] = 0;
        end
        m_sync.push_back(btn);
        void'(m_sync.pop_front());
        m_cyc++;
    endtask

    task automatic check_outputs();
        bit eq;
        eq = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            chk($sformatf("%s_cnt%0d", phase, i), ch_count(i), 32'(m_cnt[i]));
            if (m_cnt[i] != m_cnt[0]) eq = 1'b0;
        end
        chk({phase, "_press"}, 32'(press), 32'(m_press));
        chk({phase, "_all_equal"}, 32'(all_equal), 32'(eq));
        chk({phase, "_all_value"}, 32'(all_value), 32'(m_cnt[0]));
    endtask

    task automatic step(input int n);
        repeat (n) begin
            model_edge();
            @(posedge CLK);
            #1;
            check_outputs();
        end
    endtask

    task automatic check_reset_state(input string tag);
        for (int i = 0; i < NUM_CH; i++) chk($sformatf("%s_cnt%0d", tag, i), ch_count(i), 32'd0);
        chk({tag, "_press"}, 32'(press), 32'd0);
        chk({tag, "_all_equal"}, 32'(all_equal), 32'd1);
        chk({tag, "_all_value"}, 32'(all_value), 32'd0);
    endtask

    initial begin
        RST_N = 1'b1;
        EN    = 1'b0;
        DIR   = 1'b0;
        CLR   = 1'b0;
        btn   = '0;
        #1 RST_N = 1'b0;
        #1 check_reset_state("reset");
        repeat (2) @(posedge CLK);
        #1 RST_N = 1'b1;
        model_reset();
        EN = 1'b1;

        phase = "single";
        btn[0] = 1'b1;
        step(2);
        chk("single_no_early_press", 32'(press), 32'd0);
        step(1);
        chk("single_press_lat3", 32'(press), 32'd1);
        step(2);
        btn = '0;
        step(40);
        chk("single_ch0", ch_count(0), 32'd1);
        chk("single_ch1", ch_count(1), 32'd0);
        chk("single_neq", 32'(all_equal), 32'd0);

        phase = "hold";
        btn[1] = 1'b1;
        step(200);
        btn = '0;
        step(40);
        btn[1] = 1'b1;
        step(3);
        btn[1] = 1'b0;
        step(9);
        btn[1] = 1'b1;
        step(4);
        btn = '0;
        step(40);
        chk("hold_ch1", ch_count(1), 32'd2);

        phase = "wrap";
        for (int k = 0; k < MODULO; k++) begin
            btn[2] = 1'b1;
            step(3);
            btn = '0;
            step(35);
            chk($sformatf("wrap_ch2_%0d", k), ch_count(2), 32'((k + 1) % MODULO));
        end
        DIR = 1'b1;
        btn[2] = 1'b1;
        step(3);
        btn = '0;
        step(35);
        chk("wrap_down_ch2", ch_count(2), 32'(MODULO - 1));
        DIR = 1'b0;

        phase = "enable";
        EN  = 1'b0;
        btn = '1;
        step(10);
        btn = '0;
        step(5);
        chk("en_off_ch0", ch_count(0), 32'd1);
        chk("en_off_ch1", ch_count(1), 32'd2);
        chk("en_off_ch2", ch_count(2), 32'(MODULO - 1));
        btn[0] = 1'b1;
        step(5);
        EN = 1'b1;
        step(40);
        chk("en_held_ch0", ch_count(0), 32'd1);
        btn = '0;
        step(5);
        btn[0] = 1'b1;
        step(3);
        btn = '0;
        step(35);
        chk("en_repress_ch0", ch_count(0), 32'd2);

        phase = "clear";
        btn[0] = 1'b1;
        step(2);
        CLR = 1'b1;
        step(1);
        CLR = 1'b0;
        chk("clr_press0", 32'(press), 32'd1);
        chk("clr_ch0", ch_count(0), 32'd0);
        chk("clr_ch1", ch_count(1), 32'd0);
        chk("clr_ch2", ch_count(2), 32'd0);
        btn = '0;
        step(5);
        btn[0] = 1'b1;
        step(10);
        btn = '0;
        step(40);
        chk("clr_relock_ch0", ch_count(0), 32'd0);

        phase = "equal";
        btn = '1;
        step(3);
        btn = '0;
        step(40);
        chk("eq_all_equal", 32'(all_equal), 32'd1);
        chk("eq_all_value", 32'(all_value), 32'd1);
        btn[0] = 1'b1;
        step(3);
        step(10);
        #2 RST_N = 1'b0;
        #1 check_reset_state("midlock_reset");
        repeat (2) @(posedge CLK);
        #1 check_reset_state("in_reset");
        RST_N = 1'b1;
        model_reset();
        phase = "post_reset";
        step(3);
        chk("post_reset_ch0", ch_count(0), 32'd1);
        btn = '0;
        step(40);

        phase = "random";
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if ($urandom_range(0, 24) == 0) btn[i] = ~btn[i];
            end
            if ($urandom_range(0, 299) == 0) EN = ~EN;
            if ($urandom_range(0, 59) == 0) DIR = ~DIR;
            CLR = ($urandom_range(0, 199) == 0);
            step(1);
        end
        CLR = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
